// File: rtl/usb_fs_rx_phy_pkg.sv
// Shared types and constants for the full-speed USB receive front end.
// Also used by the downstream PID/packet tracker.
package usb_fs_rx_phy_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_st_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HUNT,
    RX_DATA,
    RX_EOP,
    RX_ABORT
  } rx_state_t;

  // Decoded SYNC after LSB-first shifting: wire order 0000_0001 (KJKJKJKK).
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  function automatic logic is_jk(input line_st_t ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_fs_rx_phy_if.sv
// Byte stream with packet framing from the USB receive front end.
interface usb_fs_rx_phy_if;
  logic       rx_active;
  logic       rx_sop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_err;

  modport master (output rx_active, rx_sop, rx_data, rx_valid, rx_eop, rx_err);
  modport slave  (input  rx_active, rx_sop, rx_data, rx_valid, rx_eop, rx_err);
endinterface

// File: rtl/usb_fs_rx_phy_dpll.sv
// Line synchroniser and bit-timing recovery: syncs D+/D-, reports line state,
// and strobes once per bit near the middle of the bit cell.
module usb_rx_dpll
  import usb_fs_rx_phy_pkg::*;
#(
  parameter int OVS         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     dp_i,
  input  logic     dm_i,
  output line_st_t line_st,
  output logic     j2k,
  output logic     strobe
);
  localparam int PW = $clog2(OVS);

  logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d;
  logic [SYNC_STAGES-1:0] dm_sync_q, dm_sync_d;
  line_st_t               line_prev_q, line_prev_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   jk_change;

  always_comb begin
    dp_sync_d   = {dp_sync_q[SYNC_STAGES-2:0], dp_i};
    dm_sync_d   = {dm_sync_q[SYNC_STAGES-2:0], dm_i};
    line_st     = line_st_t'({dm_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1]});
    line_prev_d = line_st;
    // Only J<->K transitions carry timing; SE0/SE1 edges are skewed on real buses.
    jk_change   = is_jk(line_st) && is_jk(line_prev_q) && (line_st != line_prev_q);
    j2k         = (line_st == LS_K) && (line_prev_q == LS_J);
    phase_d     = jk_change ? '0 : phase_q + PW'(1);
    strobe      = (phase_q == PW'(OVS / 2 - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_sync_q   <= '1;
      dm_sync_q   <= '0;
      line_prev_q <= LS_J;
      phase_q     <= '0;
    end else begin
      dp_sync_q   <= dp_sync_d;
      dm_sync_q   <= dm_sync_d;
      line_prev_q <= line_prev_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front end: NRZI decode, unstuffing, SYNC/EOP framing, byte output.
// Optional bus-reset detector enabled by defining USB_RX_BUS_RESET_EN.
module usb_fs_rx_phy
  import usb_fs_rx_phy_pkg::*;
#(
  parameter int OVS         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RST_BITS    = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dp_i,
  input  logic                  dm_i,
  input  logic                  rx_en,
  output logic [1:0]            line_st,
  output logic                  bus_reset,
  usb_fs_rx_phy_if.master       rx
);
  line_st_t  ls, prev_lvl_q, prev_lvl_d;
  logic      j2k, strobe, bus_rst, kill;
  rx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, shift_nx, byte_sr_q, byte_sr_d, data_q, data_d;
  logic [4:0] hunt_cnt_q, hunt_cnt_d;
  logic [2:0] ones_q, ones_d, bit_cnt_q, bit_cnt_d;
  logic [1:0] se0_cnt_q, se0_cnt_d;
  logic [3:0] j_cnt_q, j_cnt_d;
  logic active_q, active_d, sop_q, sop_d, valid_q, valid_d, eop_q, eop_d, err_q, err_d;
  logic bit_dec, stuff_slot;

  usb_rx_dpll #(.OVS(OVS), .SYNC_STAGES(SYNC_STAGES)) u_dpll (
    .clk(clk), .rst(rst), .dp_i(dp_i), .dm_i(dm_i),
    .line_st(ls), .j2k(j2k), .strobe(strobe)
  );

  always_comb begin
    bit_dec    = (ls == prev_lvl_q);
    shift_nx   = {bit_dec, shift_q[7:1]};
    stuff_slot = (ones_q == 3'd6);
    kill       = !rx_en || bus_rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RX_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE:  if (j2k) state_d = RX_HUNT;
        RX_HUNT: if (strobe) begin
          if (!is_jk(ls))                  state_d = RX_IDLE;
          else if (shift_nx == SYNC_PATTERN) state_d = RX_DATA;
          else if (hunt_cnt_q == 5'd16)    state_d = RX_IDLE;
        end
        RX_DATA: if (strobe) begin
          if (ls == LS_SE0)                               state_d = RX_EOP;
          else if (ls == LS_SE1 || (stuff_slot && bit_dec)) state_d = RX_ABORT;
        end
        RX_EOP:   if (strobe && (ls != LS_SE0 || se0_cnt_q == 2'd3)) state_d = RX_IDLE;
        RX_ABORT: if (strobe && ls == LS_J && j_cnt_q == 4'd7)       state_d = RX_IDLE;
        default:  state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    prev_lvl_d = prev_lvl_q;
    shift_d    = shift_q;
    hunt_cnt_d = hunt_cnt_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    byte_sr_d  = byte_sr_q;
    se0_cnt_d  = se0_cnt_q;
    j_cnt_d    = j_cnt_q;
    data_d     = data_q;
    active_d   = active_q;
    sop_d      = 1'b0;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    if (kill) begin
      eop_d    = active_q;
      err_d    = active_q;
      active_d = 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: if (j2k) begin
          prev_lvl_d = LS_J;
          shift_d    = '0;
          hunt_cnt_d = '0;
        end
        RX_HUNT: if (strobe && is_jk(ls)) begin
          prev_lvl_d = ls;
          shift_d    = shift_nx;
          hunt_cnt_d = hunt_cnt_q + 5'd1;
          if (shift_nx == SYNC_PATTERN) begin
            sop_d     = 1'b1;
            active_d  = 1'b1;
            ones_d    = '0;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: if (strobe) begin
          if (ls == LS_SE0) begin
            se0_cnt_d = 2'd1;
          end else if (ls == LS_SE1 || (stuff_slot && bit_dec)) begin
            eop_d    = 1'b1;
            err_d    = 1'b1;
            active_d = 1'b0;
            j_cnt_d  = '0;
          end else begin
            prev_lvl_d = ls;
            if (stuff_slot) begin
              ones_d = '0;  // stuff bit: consumed, not part of the byte
            end else begin
              byte_sr_d[bit_cnt_q] = bit_dec;
              ones_d    = bit_dec ? ones_q + 3'd1 : 3'd0;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                valid_d = 1'b1;
                data_d  = byte_sr_d;
              end
            end
          end
        end
        RX_EOP: if (strobe) begin
          if (ls == LS_J) begin
            eop_d    = 1'b1;
            err_d    = (bit_cnt_q != 3'd0);
            active_d = 1'b0;
          end else if (ls != LS_SE0 || se0_cnt_q == 2'd3) begin
            eop_d    = 1'b1;
            err_d    = 1'b1;
            active_d = 1'b0;
          end else begin
            se0_cnt_d = se0_cnt_q + 2'd1;
          end
        end
        RX_ABORT: if (strobe) j_cnt_d = (ls == LS_J) ? j_cnt_q + 4'd1 : 4'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_lvl_q <= LS_J;
      shift_q    <= '0;
      hunt_cnt_q <= '0;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      byte_sr_q  <= '0;
      se0_cnt_q  <= '0;
      j_cnt_q    <= '0;
      data_q     <= '0;
      active_q   <= 1'b0;
      sop_q      <= 1'b0;
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_lvl_q <= prev_lvl_d;
      shift_q    <= shift_d;
      hunt_cnt_q <= hunt_cnt_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_sr_q  <= byte_sr_d;
      se0_cnt_q  <= se0_cnt_d;
      j_cnt_q    <= j_cnt_d;
      data_q     <= data_d;
      active_q   <= active_d;
      sop_q      <= sop_d;
      valid_q    <= valid_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
    end
  end

`ifdef USB_RX_BUS_RESET_EN
  localparam int RW = $clog2(RST_BITS + 1);
  logic [RW-1:0] se0_bits_q, se0_bits_d;
  logic          bus_reset_q, bus_reset_d;

  // Saturating SE0 length in bit-times; any non-SE0 line state clears it at once.
  always_comb begin
    se0_bits_d = se0_bits_q;
    if (ls != LS_SE0)                                   se0_bits_d = '0;
    else if (strobe && se0_bits_q != RW'(RST_BITS))     se0_bits_d = se0_bits_q + 1'b1;
    bus_reset_d = (ls == LS_SE0) && (se0_bits_d == RW'(RST_BITS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      se0_bits_q  <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      se0_bits_q  <= se0_bits_d;
      bus_reset_q <= bus_reset_d;
    end
  end

  assign bus_rst = bus_reset_q;
`else
  logic unused_rst_bits;
  assign unused_rst_bits = (RST_BITS > 0);
  assign bus_rst         = 1'b0;
`endif

  assign bus_reset    = bus_rst;
  assign line_st      = ls;
  assign rx.rx_active = active_q;
  assign rx.rx_sop    = sop_q;
  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_eop    = eop_q;
  assign rx.rx_err    = err_q;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Scoreboard bench for usb_fs_rx_phy: packets are encoded on the wire from byte lists,
// expected SOP/byte/EOP events are queued, and a monitor pops them as the DUT emits them.
module tb_usb_fs_rx_phy;
  localparam logic [1:0] S_SE0 = 2'b00, S_J = 2'b01, S_K = 2'b10;
  localparam logic [1:0] EV_SOP = 2'd0, EV_BYTE = 2'd1, EV_EOP = 2'd2;
  localparam int IDLE_BITS = 12;

  logic clk = 1'b0, rst = 1'b0, dp_i = 1'b1, dm_i = 1'b0, rx_en = 1'b0;
  logic [1:0] line_st;
  logic       bus_reset;

  usb_fs_rx_phy_if rx_if ();

  usb_fs_rx_phy #(.OVS(4), .SYNC_STAGES(2), .RST_BITS(30)) dut (
    .clk(clk), .rst(rst), .dp_i(dp_i), .dm_i(dm_i), .rx_en(rx_en),
    .line_st(line_st), .bus_reset(bus_reset), .rx(rx_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       err;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  logic       bits[$];
  logic [1:0] syms[$];
  int checks = 0, passed = 0, pkt_no = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic take(input logic [1:0] kind, input logic [7:0] data, input logic err);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", {30'd0, kind}, 32'd3);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", {30'd0, kind}, {30'd0, e.kind});
    if (e.kind == EV_BYTE) check("rx_data", {24'd0, data}, {24'd0, e.data});
    if (e.kind == EV_EOP) begin
      check("rx_err", {31'd0, err}, {31'd0, e.err});
      check("eop_without_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    end
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_if.rx_sop)   take(EV_SOP, 8'd0, 1'b0);
      if (rx_if.rx_valid) take(EV_BYTE, rx_if.rx_data, 1'b0);
      if (rx_if.rx_eop)   take(EV_EOP, 8'd0, rx_if.rx_err);
    end
  end

  // Expected framing: SOP, the first n_bytes of pkt, then EOP with the given error flag.
  task automatic expect_pkt(input int n_bytes, input logic err);
    exp_q.push_back('{EV_SOP, 8'd0, 1'b0});
    for (int i = 0; i < n_bytes; i++) exp_q.push_back('{EV_BYTE, pkt[i], 1'b0});
    exp_q.push_back('{EV_EOP, 8'd0, err});
  endtask

  task automatic bits_from_pkt();
    bits.delete();
    foreach (pkt[i]) for (int b = 0; b < 8; b++) bits.push_back(pkt[i][b]);
  endtask

  // Wire encoding: SYNC, then bits LSB first with optional stuffing, NRZI, EOP, idle J.
  task automatic build(input bit stuff_en, input bit tail_stuff, input int n_se0);
    logic [15:0] sync_wire;
    logic [1:0]  lvl;
    int          ones;
    sync_wire = {S_K, S_K, S_J, S_K, S_J, S_K, S_J, S_K};
    syms.delete();
    for (int i = 0; i < 8; i++) syms.push_back(sync_wire[2*i +: 2]);
    lvl  = S_K;
    ones = 0;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = (lvl == S_J) ? S_K : S_J;
      syms.push_back(lvl);
      ones = bits[i] ? ones + 1 : 0;
      if (stuff_en && ones == 6 && (i < bits.size() - 1 || tail_stuff)) begin
        lvl = (lvl == S_J) ? S_K : S_J;
        syms.push_back(lvl);
        ones = 0;
      end
    end
    repeat (n_se0) syms.push_back(S_SE0);
    repeat (IDLE_BITS) syms.push_back(S_J);
  endtask

  // Each symbol nominally 4 clocks; with jitter every edge lands 0 or 1 sample late.
  task automatic send(input bit jit, input int drop_at);
    int jp, jn;
    jp = 0;
    foreach (syms[i]) begin
      jn = (jit && i + 1 < syms.size()) ? int'($urandom_range(0, 1)) : 0;
      if (i == drop_at) rx_en = 1'b0;
      {dm_i, dp_i} = syms[i];
      repeat (4 + jn - jp) @(negedge clk);
      jp = jn;
    end
    rx_en = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("events_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    check("rx_active_idle", {31'd0, rx_if.rx_active}, 32'd0);
    check("line_st_idle", {30'd0, line_st}, 32'd1);
  endtask

  task automatic run(input string tag, input bit jit, input bit stuff_en, input bit tail_stuff,
                     input int n_se0, input int drop_at);
    pkt_no++;
    $display("pkt %0d %s: bytes=%0d bits=%0d se0=%0d jitter=%0d", pkt_no, tag, pkt.size(),
             bits.size(), n_se0, jit);
    build(stuff_en, tail_stuff, n_se0);
    send(jit, drop_at);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_line_st", {30'd0, line_st}, 32'd1);
    check("reset_rx_active", {31'd0, rx_if.rx_active}, 32'd0);
    check("reset_pulses", {28'd0, rx_if.rx_sop, rx_if.rx_valid, rx_if.rx_eop, rx_if.rx_err}, 32'd0);
    check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check("reset_bus_reset", {31'd0, bus_reset}, 32'd0);
    rst   = 1'b1;
    rx_en = 1'b1;
    repeat (20) @(negedge clk);

    pkt = '{8'h69, 8'hA5};  bits_from_pkt(); expect_pkt(2, 1'b0); run("basic", 0, 1, 1, 2, -1);
    pkt = '{8'hFF, 8'h3F};  bits_from_pkt(); expect_pkt(2, 1'b0); run("stuffing", 0, 1, 1, 2, -1);
    pkt = '{8'hFF};         bits_from_pkt(); expect_pkt(0, 1'b1); run("seven_ones", 0, 0, 1, 2, -1);

    pkt = '{8'($urandom)};  bits_from_pkt();
    for (int i = 0; i < 4; i++) bits.push_back(1'($urandom));
    expect_pkt(1, 1'b1); run("partial_byte", 0, 1, 1, 2, -1);

    pkt.delete();
    for (int i = 0; i < 64; i++) pkt.push_back(8'($urandom));
    bits_from_pkt(); expect_pkt(64, 1'b0); run("jitter64", 1, 1, 1, 2, -1);

    for (int n = 0; n < 6; n++) begin
      pkt.delete();
      repeat ($urandom_range(1, 8)) pkt.push_back(8'($urandom));
      bits_from_pkt(); expect_pkt(pkt.size(), 1'b0);
      run("random", 1'($urandom), 1, 1'($urandom), $urandom_range(1, 3), -1);
    end

    pkt = '{8'($urandom), 8'hFC}; bits_from_pkt(); expect_pkt(2, 1'b0);
    run("ones_then_eop", 0, 1, 0, 2, -1);

    pkt = '{8'h5A, 8'($urandom)}; bits_from_pkt(); expect_pkt(2, 1'b1);
    run("long_se0", 0, 1, 1, 4, -1);

    // rx_en drops four bits into the second byte: first byte survives, then an error EOP.
    pkt = '{8'h00, 8'($urandom), 8'($urandom)}; bits_from_pkt(); expect_pkt(1, 1'b1);
    run("rx_en_drop", 0, 1, 1, 2, 20);

    {dm_i, dp_i} = S_SE0;
    repeat (128) @(negedge clk);
`ifdef USB_RX_BUS_RESET_EN
    check("bus_reset_after_se0", {31'd0, bus_reset}, 32'd1);
`else
    check("bus_reset_disabled", {31'd0, bus_reset}, 32'd0);
`endif
    {dm_i, dp_i} = S_J;
    repeat (4) @(negedge clk);
    check("bus_reset_released", {31'd0, bus_reset}, 32'd0);
    check("no_stray_events", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
